// File: rtl/uart_keyword_responder.sv
// uart_keyword_responder
//   Receives an oversampled 8N1 stream, watches for a KEY_LEN-byte keyword and
//   answers each match with a RESP_LEN-byte string. One response can be queued
//   behind the one being sent; further matches while the queue is full are
//   counted but dropped.
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_rx            serial input, asynchronous, idle high
//   o_tx            serial output, idle high
//   o_busy          response being sent or pending
//   o_match_pulse   one-cycle strobe per keyword match
//   o_resp_dropped  one-cycle strobe when a match finds the queue full
//   o_frame_err     one-cycle strobe when a stop bit is sampled low
//   o_match_count   wrapping count of matches
module uart_keyword_responder #(
    parameter int unsigned           BAUD_DIV   = 5208,
    parameter int unsigned           OVERSAMPLE = 8,
    parameter int unsigned           KEY_LEN    = 5,
    parameter logic [8*KEY_LEN-1:0]  KEY        = 40'h4D4152434F,
    parameter int unsigned           RESP_LEN   = 4,
    parameter logic [8*RESP_LEN-1:0] RESP       = 32'h504F4C4F,
    parameter int unsigned           CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_match_pulse,
    output logic             o_resp_dropped,
    output logic             o_frame_err,
    output logic [CNT_W-1:0] o_match_count
);

    localparam int unsigned TICK_DIV = BAUD_DIV / OVERSAMPLE;
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUB_W    = $clog2(OVERSAMPLE);
    localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BYTE_W   = (RESP_LEN > 1) ? $clog2(RESP_LEN) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [SUB_W-1:0]  SUB_FULL  = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]  SUB_HALF  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(RESP_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    // ------------------------------------------------------------------
    // RX synchroniser and receive FSM
    // ------------------------------------------------------------------
    logic             r_rx_meta, r_rx_sync;
    rx_state_e        r_rx_state, w_rx_state_d;
    logic [DIV_W-1:0] r_div, w_div_d;
    logic [SUB_W-1:0] r_sub, w_sub_d;
    logic [2:0]       r_bit_cnt, w_bit_cnt_d;
    logic [7:0]       r_rx_data, w_rx_data_d;
    logic             w_tick, w_sample, w_byte_valid, w_frame_err;

    always_comb begin
        w_tick       = (r_div == DIV_LAST);
        // START samples at half a bit to land mid-bit for the rest of the frame
        w_sample     = w_tick && (r_sub == ((r_rx_state == StStart) ? SUB_HALF : SUB_FULL));
        w_rx_state_d = r_rx_state;
        w_div_d      = w_tick ? '0 : r_div + 1'b1;
        w_sub_d      = w_sample ? '0 : (w_tick ? r_sub + 1'b1 : r_sub);
        w_bit_cnt_d  = r_bit_cnt;
        w_rx_data_d  = r_rx_data;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        unique case (r_rx_state)
            StIdle: begin
                w_div_d     = '0;
                w_sub_d     = '0;
                w_bit_cnt_d = '0;
                if (!r_rx_sync) w_rx_state_d = StStart;
            end
            StStart: begin
                if (w_sample) w_rx_state_d = r_rx_sync ? StIdle : StData;
            end
            StData: begin
                if (w_sample) begin
                    w_rx_data_d = {r_rx_sync, r_rx_data[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_rx_state_d = StStop;
                end
            end
            StStop: begin
                if (w_sample) begin
                    if (r_rx_sync) begin
                        w_byte_valid = 1'b1;
                        w_rx_state_d = StIdle;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_rx_state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                w_div_d = '0;
                w_sub_d = '0;
                if (r_rx_sync) w_rx_state_d = StIdle;
            end
            default: w_rx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= StIdle;
            r_div      <= '0;
            r_sub      <= '0;
            r_bit_cnt  <= '0;
            r_rx_data  <= '0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_d;
            r_div      <= w_div_d;
            r_sub      <= w_sub_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_rx_data  <= w_rx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Keyword matcher
    // ------------------------------------------------------------------
    logic [8*KEY_LEN-1:0] r_window, w_window_shift;
    logic                 w_match;
    logic                 r_match_pulse, r_frame_err;
    logic [CNT_W-1:0]     r_match_count;

    if (KEY_LEN == 1) begin : g_win_one
        assign w_window_shift = r_rx_data;
    end else begin : g_win_many
        assign w_window_shift = {r_window[8*KEY_LEN-9:0], r_rx_data};
    end

    assign w_match = w_byte_valid && (w_window_shift == KEY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window      <= '0;
            r_match_pulse <= 1'b0;
            r_frame_err   <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_match_pulse <= w_match;
            r_frame_err   <= w_frame_err;
            // Clearing on a match keeps consecutive matches from sharing bytes
            if (w_match) begin
                r_window      <= '0;
                r_match_count <= r_match_count + 1'b1;
            end else if (w_byte_valid) begin
                r_window <= w_window_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response transmitter with one-deep pending queue
    // ------------------------------------------------------------------
    logic              r_tx_active, w_tx_active_d;
    logic              r_pending, w_pending_d;
    logic [BAUD_W-1:0] r_baud, w_baud_d;
    logic [3:0]        r_bit_idx, w_bit_idx_d;
    logic [BYTE_W-1:0] r_byte_idx, w_byte_idx_d;
    logic              r_tx, w_tx_d;
    logic [7:0]        w_cur_byte;
    logic [9:0]        w_frame;
    logic              w_last_cycle, w_start;

    always_comb begin
        w_last_cycle  = r_tx_active && (r_baud == BAUD_LAST) && (r_bit_idx == 4'd9) &&
                        (r_byte_idx == BYTE_LAST);
        w_start       = 1'b0;
        w_tx_active_d = r_tx_active;
        w_pending_d   = r_pending;
        w_baud_d      = r_baud;
        w_bit_idx_d   = r_bit_idx;
        w_byte_idx_d  = r_byte_idx;

        if (!r_tx_active) begin
            w_start = r_match_pulse;
        end else if (w_last_cycle) begin
            // A match landing in the final cycle chains straight on, no gap
            if (r_pending || r_match_pulse) begin
                w_start = 1'b1;
            end else begin
                w_tx_active_d = 1'b0;
            end
            w_pending_d = 1'b0;
        end else begin
            if (r_match_pulse) w_pending_d = 1'b1;
            if (r_baud == BAUD_LAST) begin
                w_baud_d = '0;
                if (r_bit_idx == 4'd9) begin
                    w_bit_idx_d  = '0;
                    w_byte_idx_d = r_byte_idx + 1'b1;
                end else begin
                    w_bit_idx_d = r_bit_idx + 4'd1;
                end
            end else begin
                w_baud_d = r_baud + 1'b1;
            end
        end

        if (w_start) begin
            w_tx_active_d = 1'b1;
            w_baud_d      = '0;
            w_bit_idx_d   = '0;
            w_byte_idx_d  = '0;
        end

        w_cur_byte = '0;
        for (int i = 0; i < RESP_LEN; i++) begin
            if (w_byte_idx_d == BYTE_W'(i)) w_cur_byte = RESP[8*(RESP_LEN-1-i) +: 8];
        end
        w_frame = {1'b1, w_cur_byte, 1'b0};
        w_tx_d  = w_tx_active_d ? w_frame[w_bit_idx_d] : 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_active <= 1'b0;
            r_pending   <= 1'b0;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_tx        <= 1'b1;
        end else begin
            r_tx_active <= w_tx_active_d;
            r_pending   <= w_pending_d;
            r_baud      <= w_baud_d;
            r_bit_idx   <= w_bit_idx_d;
            r_byte_idx  <= w_byte_idx_d;
            r_tx        <= w_tx_d;
        end
    end

    assign o_tx           = r_tx;
    assign o_busy         = r_tx_active | r_pending;
    assign o_match_pulse  = r_match_pulse;
    // Registered terms only, so this coincides with o_match_pulse
    assign o_resp_dropped = r_match_pulse & r_tx_active & r_pending;
    assign o_frame_err    = r_frame_err;
    assign o_match_count  = r_match_count;

endmodule

// File: tb/tb_uart_keyword_responder.sv
// Directed bench for uart_keyword_responder at 16 clocks/bit, 8x oversampling.
// Instance dut uses the default keyword "MARCO"; instance dut_b uses the single
// byte keyword "M" so that matches arrive faster than a response takes to send.
module tb_uart_keyword_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_drv = 1'b1;
    logic       sel_b = 1'b0;
    logic       rx_a, rx_b;
    logic       tx, busy, match_pulse, resp_dropped, frame_err;
    logic [7:0] match_count;
    logic       tx_b, busy_b, match_pulse_b, resp_dropped_b, frame_err_b;
    logic [7:0] match_count_b;

    assign rx_a = sel_b ? 1'b1 : rx_drv;
    assign rx_b = sel_b ? rx_drv : 1'b1;

    always #5 clk = ~clk;

    uart_keyword_responder #(
        .BAUD_DIV  (16),
        .OVERSAMPLE(8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx          (rx_a),
        .o_tx          (tx),
        .o_busy        (busy),
        .o_match_pulse (match_pulse),
        .o_resp_dropped(resp_dropped),
        .o_frame_err   (frame_err),
        .o_match_count (match_count)
    );

    uart_keyword_responder #(
        .BAUD_DIV  (16),
        .OVERSAMPLE(8),
        .KEY_LEN   (1),
        .KEY       (8'h4D)
    ) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx          (rx_b),
        .o_tx          (tx_b),
        .o_busy        (busy_b),
        .o_match_pulse (match_pulse_b),
        .o_resp_dropped(resp_dropped_b),
        .o_frame_err   (frame_err_b),
        .o_match_count (match_count_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int cyc = 0;
    int n_match = 0, n_ferr = 0, n_drop = 0, n_runs = 0, run = 0, last_run = 0;
    int t_match = 0, t_busy_rise = 0, n_tx_low = 0;
    logic tx_at_rise = 1'b1, prev_busy = 1'b0;
    int n_match_b = 0, n_drop_b = 0, n_both_b = 0, n_runs_b = 0, run_b = 0, last_run_b = 0;

    always @(negedge clk) begin
        cyc++;
        if (match_pulse) begin
            n_match++;
            t_match = cyc;
        end
        if (frame_err) n_ferr++;
        if (resp_dropped) n_drop++;
        if (!tx) n_tx_low++;
        if (busy && !prev_busy) begin
            t_busy_rise = cyc;
            tx_at_rise  = tx;
        end
        prev_busy = busy;
        if (busy) run++;
        else if (run != 0) begin
            last_run = run;
            n_runs++;
            run = 0;
        end
        if (match_pulse_b) n_match_b++;
        if (resp_dropped_b) n_drop_b++;
        if (resp_dropped_b && match_pulse_b) n_both_b++;
        if (busy_b) run_b++;
        else if (run_b != 0) begin
            last_run_b = run_b;
            n_runs_b++;
            run_b = 0;
        end
    end

    // Serial decoders: frame = {stop, data}
    logic [8:0] q_tx[$];
    logic [8:0] q_tx_b[$];

    task automatic decode(input bit which);
        logic [8:0] f;
        forever begin
            @(negedge clk);
            if ((which ? tx_b : tx) == 1'b0) begin
                repeat (8) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    repeat (16) @(negedge clk);
                    f[i] = which ? tx_b : tx;
                end
                if (which) q_tx_b.push_back(f);
                else q_tx.push_back(f);
            end
        end
    endtask

    initial decode(1'b0);
    initial decode(1'b1);

    // ---------------- stimulus helpers ----------------
    task automatic bit_out(input logic v);
        rx_drv = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_bit);
        if (!stop_bit) begin
            bit_out(1'b1);
            bit_out(1'b1);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic idle(input int n);
        rx_drv = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit which, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((which ? busy_b : busy) && n < 3000);
        check_eq(tag, which ? busy_b : busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
    endtask

    logic [7:0] polo[4] = '{8'h50, 8'h4F, 8'h4C, 8'h4F};

    task automatic check_resp(input bit which, input int n_resp, input string tag);
        int sz;
        sz = which ? q_tx_b.size() : q_tx.size();
        check_eq({tag, "_nbytes"}, sz, 4 * n_resp);
        for (int i = 0; i < sz && i < 4 * n_resp; i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), which ? q_tx_b[i] : q_tx[i],
                     {1'b1, polo[i % 4]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    int snap_runs, snap_ferr, snap_low;

    initial begin
        #21;
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_match", match_pulse, 1'b0);
        check_eq("rst_drop", resp_dropped, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_count", match_count, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // T1: single keyword, full response timing
        send_str("MARCO");
        wait_idle(1'b0, "t1_idle");
        check_eq("t1_count", match_count, 8'd1);
        check_eq("t1_pulses", n_match, 1);
        check_eq("t1_busy_lat", t_busy_rise - t_match, 1);
        check_eq("t1_tx_at_rise", tx_at_rise, 1'b0);
        check_eq("t1_busy_len", last_run, 640);
        check_resp(1'b0, 1, "t1");

        // T2: overlapping prefix, then back-to-back keywords
        pulse_reset();
        q_tx.delete();
        snap_runs = n_runs;
        send_str("MAMARCO");
        wait_idle(1'b0, "t2a_idle");
        check_eq("t2a_count", match_count, 8'd1);
        send_str("MARCOMARCO");
        wait_idle(1'b0, "t2b_idle");
        check_eq("t2b_count", match_count, 8'd3);
        check_eq("t2_runs", n_runs - snap_runs, 3);
        check_eq("t2_busy_len", last_run, 640);
        check_resp(1'b0, 3, "t2");

        // T3: bad frame between "MARC" and "O" must not shift the window
        q_tx.delete();
        snap_ferr = n_ferr;
        send_str("MARC");
        send_byte(8'h58, 1'b0);
        send_str("O");
        wait_idle(1'b0, "t3a_idle");
        check_eq("t3_ferr", n_ferr - snap_ferr, 1);
        check_eq("t3a_count", match_count, 8'd4);
        send_str("MARCO");
        wait_idle(1'b0, "t3b_idle");
        check_eq("t3b_count", match_count, 8'd5);
        check_resp(1'b0, 2, "t3");

        // T4: 2-cycle low glitch between "MARC" and "O" is rejected
        snap_ferr = n_ferr;
        send_str("MARC");
        idle(20);
        rx_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(40);
        send_str("O");
        wait_idle(1'b0, "t4_idle");
        check_eq("t4_ferr", n_ferr - snap_ferr, 0);
        check_eq("t4_count", match_count, 8'd6);

        // T5: reset during the third response byte
        send_str("MARCO");
        repeat (360) @(posedge clk);
        #1;
        check_eq("t5_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx", tx, 1'b1);
        check_eq("t5_rst_busy", busy, 1'b0);
        check_eq("t5_rst_count", match_count, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap_low = n_tx_low;
        idle(200);
        check_eq("t5_no_partial", n_tx_low - snap_low, 0);
        q_tx.delete();
        send_str("MARCO");
        wait_idle(1'b0, "t5_idle");
        check_eq("t5_count", match_count, 8'd1);
        check_eq("t5_busy_len", last_run, 640);
        check_resp(1'b0, 1, "t5");

        // T6: three matches during one response (single-byte keyword)
        sel_b = 1'b1;
        idle(4);
        q_tx_b.delete();
        send_str("MMM");
        wait_idle(1'b1, "t6_idle");
        check_eq("t6_count", match_count_b, 8'd3);
        check_eq("t6_pulses", n_match_b, 3);
        check_eq("t6_drops", n_drop_b, 1);
        check_eq("t6_drop_with_match", n_both_b, 1);
        check_eq("t6_runs", n_runs_b, 1);
        check_eq("t6_busy_len", last_run_b, 1280);
        check_resp(1'b1, 2, "t6");
        check_eq("t6_a_untouched", match_count, 8'd1);
        sel_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
